// File: rtl/mem_tdp_bw_mdl_if.sv
`default_nettype none
// =============================================================================
// Module   : mem_tdp_bw_mdl_if
// Brief    : Two-port access bundle for the byte-lane true-dual-port memory.
// Revision : 1.0 - initial release
// =============================================================================
interface mem_tdp_bw_mdl_if #(
    parameter int DATA_W = 32,
    parameter int LANE_W = 8,
    parameter int ADDR_W = 12
);
    localparam int LANES = DATA_W / LANE_W;

    logic              a_ce;
    logic [LANES-1:0]  a_wen;
    logic [ADDR_W-1:0] a_addr;
    logic [DATA_W-1:0] a_din;
    logic [DATA_W-1:0] a_qout;
    logic              a_qvld;

    logic              b_ce;
    logic [LANES-1:0]  b_wen;
    logic [ADDR_W-1:0] b_addr;
    logic [DATA_W-1:0] b_din;
    logic [DATA_W-1:0] b_qout;
    logic              b_qvld;

    logic              coll;

    modport master (
        output a_ce, a_wen, a_addr, a_din,
        output b_ce, b_wen, b_addr, b_din,
        input  a_qout, a_qvld, b_qout, b_qvld, coll
    );

    modport slave (
        input  a_ce, a_wen, a_addr, a_din,
        input  b_ce, b_wen, b_addr, b_din,
        output a_qout, a_qvld, b_qout, b_qvld, coll
    );
endinterface
`default_nettype wire

// File: rtl/mem_tdp_bw_mdl.sv
`default_nettype none
// =============================================================================
// Module   : mem_tdp_bw_mdl
// Brief    : True-dual-port byte-lane-writable memory model with read pipeline.
// Revision : 1.0 - initial release
// =============================================================================
module mem_tdp_bw_mdl #(
    parameter int DATA_W    = 32,
    parameter int LANE_W    = 8,
    parameter int ADDR_W    = 12,
    parameter int RD_LAT    = 1,
    parameter int WR_MODE   = 0,
    parameter int INIT_ZERO = 1
) (
    input  wire logic         clk,
    input  wire logic         rstn,
    mem_tdp_bw_mdl_if.slave   bus
);
    localparam int LANES = DATA_W / LANE_W;
    localparam int DEPTH = 2 ** ADDR_W;

    generate
        if (RD_LAT < 1 || RD_LAT > 4 || (DATA_W % LANE_W) != 0 || WR_MODE > 2) begin : g_param_err
            $error("mem_tdp_bw_mdl: illegal parameter combination");
        end
    endgenerate

    logic [DATA_W-1:0] r_mem [DEPTH];

    // Index 0 is port A, index 1 is port B
    logic [1:0]                   w_ce;
    logic [1:0][LANES-1:0]        w_wen;
    logic [1:0][ADDR_W-1:0]       w_addr;
    logic [1:0][DATA_W-1:0]       w_din;
    logic [1:0][DATA_W-1:0]       w_qout;
    logic [1:0]                   w_qvld;
    logic                         r_coll;

    assign w_ce   = {bus.b_ce,   bus.a_ce};
    assign w_wen  = {bus.b_wen,  bus.a_wen};
    assign w_addr = {bus.b_addr, bus.a_addr};
    assign w_din  = {bus.b_din,  bus.a_din};

    assign bus.a_qout = w_qout[0];
    assign bus.a_qvld = w_qvld[0];
    assign bus.b_qout = w_qout[1];
    assign bus.b_qvld = w_qvld[1];
    assign bus.coll   = r_coll;

    // Port B is written first so port A's assignment wins on shared lanes
    generate
        if (INIT_ZERO != 0) begin : g_mem_init
            always_ff @(posedge clk or negedge rstn) begin
                if (!rstn) begin
                    for (int w = 0; w < DEPTH; w++) begin
                        r_mem[w] <= '0;
                    end
                end else begin
                    for (int p = 1; p >= 0; p--) begin
                        for (int l = 0; l < LANES; l++) begin
                            if (w_ce[p] && w_wen[p][l]) begin
                                r_mem[w_addr[p]][l*LANE_W +: LANE_W] <= w_din[p][l*LANE_W +: LANE_W];
                            end
                        end
                    end
                end
            end
        end else begin : g_mem_noinit
            always_ff @(posedge clk) begin
                if (rstn) begin
                    for (int p = 1; p >= 0; p--) begin
                        for (int l = 0; l < LANES; l++) begin
                            if (w_ce[p] && w_wen[p][l]) begin
                                r_mem[w_addr[p]][l*LANE_W +: LANE_W] <= w_din[p][l*LANE_W +: LANE_W];
                            end
                        end
                    end
                end
            end
        end
    endgenerate

    generate
        for (genvar p = 0; p < 2; p++) begin : g_port
            logic [DATA_W-1:0] r_pd [RD_LAT];
            logic [RD_LAT-1:0] r_pv;
            logic [DATA_W-1:0] w_s1;

            // The array read sees pre-write contents, giving old data to the other port
            always_comb begin
                w_s1 = r_mem[w_addr[p]];
                for (int l = 0; l < LANES; l++) begin
                    if (w_wen[p][l]) begin
                        if (WR_MODE == 0) begin
                            w_s1[l*LANE_W +: LANE_W] = w_din[p][l*LANE_W +: LANE_W];
                        end else if (WR_MODE == 2) begin
                            w_s1[l*LANE_W +: LANE_W] = r_pd[0][l*LANE_W +: LANE_W];
                        end
                    end
                end
            end

            // Data registers only load behind a valid entry so the output holds between reads
            always_ff @(posedge clk or negedge rstn) begin
                if (!rstn) begin
                    for (int s = 0; s < RD_LAT; s++) begin
                        r_pd[s] <= '0;
                    end
                    r_pv <= '0;
                end else begin
                    r_pv[0] <= w_ce[p];
                    if (w_ce[p]) begin
                        r_pd[0] <= w_s1;
                    end
                    for (int s = 1; s < RD_LAT; s++) begin
                        r_pv[s] <= r_pv[s-1];
                        if (r_pv[s-1]) begin
                            r_pd[s] <= r_pd[s-1];
                        end
                    end
                end
            end

            assign w_qout[p] = r_pd[RD_LAT-1];
            assign w_qvld[p] = r_pv[RD_LAT-1];
        end
    endgenerate

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_coll <= 1'b0;
        end else begin
            r_coll <= w_ce[0] && w_ce[1] && (w_addr[0] == w_addr[1]) && ((w_wen[0] & w_wen[1]) != '0);
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_mem_tdp_bw_mdl.sv
`timescale 1ns/1ps
`default_nettype none
// =============================================================================
// Module   : tb_mem_tdp_bw_mdl
// Brief    : Scoreboard bench driving seven parameter variants in lock-step.
// Revision : 1.0 - initial release
// =============================================================================
module tb_mem_tdp_bw_mdl;
    localparam int NCFG   = 7;
    localparam int DATA_W = 32;
    localparam int LANE_W = 8;
    localparam int ADDR_W = 12;

    function automatic int cfg_lat(input int k);
        case (k)
            0, 1, 2: return 1;
            3:       return 2;
            4, 6:    return 3;
            default: return 4;
        endcase
    endfunction

    function automatic int cfg_mode(input int k);
        case (k)
            1, 5:    return 1;
            2, 6:    return 2;
            default: return 0;
        endcase
    endfunction

    function automatic int cfg_zero(input int k);
        return (k == 6) ? 0 : 1;
    endfunction

    logic        clk = 1'b0;
    logic        rstn;
    logic        a_ce, b_ce;
    logic [3:0]  a_wen, b_wen;
    logic [11:0] a_addr, b_addr;
    logic [31:0] a_din, b_din;

    logic [NCFG-1:0][31:0] aq, bq;
    logic [NCFG-1:0]       av, bv, cl;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NCFG; g++) begin : g_dut
        mem_tdp_bw_mdl_if #(.DATA_W(DATA_W), .LANE_W(LANE_W), .ADDR_W(ADDR_W)) u_if ();
        assign u_if.a_ce   = a_ce;
        assign u_if.a_wen  = a_wen;
        assign u_if.a_addr = a_addr;
        assign u_if.a_din  = a_din;
        assign u_if.b_ce   = b_ce;
        assign u_if.b_wen  = b_wen;
        assign u_if.b_addr = b_addr;
        assign u_if.b_din  = b_din;
        assign aq[g] = u_if.a_qout;
        assign av[g] = u_if.a_qvld;
        assign bq[g] = u_if.b_qout;
        assign bv[g] = u_if.b_qvld;
        assign cl[g] = u_if.coll;

        mem_tdp_bw_mdl #(
            .DATA_W(DATA_W), .LANE_W(LANE_W), .ADDR_W(ADDR_W),
            .RD_LAT(cfg_lat(g)), .WR_MODE(cfg_mode(g)), .INIT_ZERO(cfg_zero(g))
        ) u_dut (
            .clk  (clk),
            .rstn (rstn),
            .bus  (u_if.slave)
        );
    end

    typedef struct packed {
        logic [31:0] due;
        logic [31:0] d;
    } exp_t;

    exp_t        sbq [NCFG][2][$];
    logic [31:0] mz  [4096];
    logic [31:0] mnz [4096];
    logic [31:0] s1     [NCFG][2];
    logic [31:0] last_q [NCFG][2];
    logic        exp_coll;
    int          cyc    = 0;
    int          checks = 0;
    int          errors = 0;

    // Reference model: sees the same inputs the DUTs sample on each rising edge
    always @(posedge clk) begin
        logic        pce  [2];
        logic [3:0]  pwen [2];
        logic [11:0] padr [2];
        logic [31:0] pdin [2];
        logic [31:0] old, nv;
        exp_t        e;
        cyc = cyc + 1;
        pce[0] = a_ce;  pwen[0] = a_wen; padr[0] = a_addr; pdin[0] = a_din;
        pce[1] = b_ce;  pwen[1] = b_wen; padr[1] = b_addr; pdin[1] = b_din;
        if (rstn) begin
            for (int k = 0; k < NCFG; k++) begin
                for (int p = 0; p < 2; p++) begin
                    if (pce[p]) begin
                        old = (cfg_zero(k) != 0) ? mz[padr[p]] : mnz[padr[p]];
                        nv  = s1[k][p];
                        for (int l = 0; l < 4; l++) begin
                            if (!pwen[p][l] || cfg_mode(k) == 1)
                                nv[l*8 +: 8] = old[l*8 +: 8];
                            else if (cfg_mode(k) == 0)
                                nv[l*8 +: 8] = pdin[p][l*8 +: 8];
                        end
                        s1[k][p] = nv;
                        e.due = 32'(cyc + cfg_lat(k) - 1);
                        e.d   = nv;
                        sbq[k][p].push_back(e);
                    end
                end
            end
            for (int p = 1; p >= 0; p--) begin
                for (int l = 0; l < 4; l++) begin
                    if (pce[p] && pwen[p][l]) begin
                        mz[padr[p]][l*8 +: 8]  = pdin[p][l*8 +: 8];
                        mnz[padr[p]][l*8 +: 8] = pdin[p][l*8 +: 8];
                    end
                end
            end
            exp_coll = a_ce && b_ce && (a_addr == b_addr) && ((a_wen & b_wen) != 4'h0);
        end
    end

    always @(negedge clk) begin
        logic        qv;
        logic [31:0] qo;
        exp_t        e;
        for (int k = 0; k < NCFG; k++) begin
            for (int p = 0; p < 2; p++) begin
                qv = (p == 0) ? av[k] : bv[k];
                qo = (p == 0) ? aq[k] : bq[k];
                if (sbq[k][p].size() > 0 && sbq[k][p][0].due == 32'(cyc)) begin
                    e = sbq[k][p].pop_front();
                    checks++;
                    assert (qv === 1'b1 && qo === e.d) else begin
                        errors++;
                        $error("FAIL rd cfg%0d port%0d cyc%0d: qvld=%b qout=%h, required qvld=1 qout=%h",
                               k, p, cyc, qv, qo, e.d);
                    end
                    last_q[k][p] = e.d;
                end else begin
                    checks++;
                    assert (qv === 1'b0 && qo === last_q[k][p]) else begin
                        errors++;
                        $error("FAIL hold cfg%0d port%0d cyc%0d: qvld=%b qout=%h, required qvld=0 qout=%h",
                               k, p, cyc, qv, qo, last_q[k][p]);
                    end
                end
            end
            checks++;
            assert (cl[k] === exp_coll) else begin
                errors++;
                $error("FAIL coll cfg%0d cyc%0d: coll=%b, required %b", k, cyc, cl[k], exp_coll);
            end
        end
    end

    task automatic reset_start();
        rstn = 1'b0;
        for (int k = 0; k < NCFG; k++) begin
            for (int p = 0; p < 2; p++) begin
                sbq[k][p].delete();
                s1[k][p]     = '0;
                last_q[k][p] = '0;
            end
        end
        for (int w = 0; w < 4096; w++) mz[w] = '0;
        exp_coll = 1'b0;
    endtask

    task automatic cycle(input logic ace, input logic [3:0] awen, input logic [11:0] aaddr,
                         input logic [31:0] adin, input logic bce, input logic [3:0] bwen,
                         input logic [11:0] baddr, input logic [31:0] bdin);
        a_ce = ace; a_wen = awen; a_addr = aaddr; a_din = adin;
        b_ce = bce; b_wen = bwen; b_addr = baddr; b_din = bdin;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        repeat (n) cycle(1'b0, 4'h0, 12'h0, 32'h0, 1'b0, 4'h0, 12'h0, 32'h0);
    endtask

    initial begin
        a_ce = 1'b0; a_wen = '0; a_addr = '0; a_din = '0;
        b_ce = 1'b0; b_wen = '0; b_addr = '0; b_din = '0;
        reset_start();
        repeat (3) @(negedge clk);
        for (int k = 0; k < NCFG; k++) begin
            checks++;
            assert (aq[k] === 32'h0 && av[k] === 1'b0 && bq[k] === 32'h0 && bv[k] === 1'b0 && cl[k] === 1'b0) else begin
                errors++;
                $error("FAIL reset cfg%0d: aq=%h av=%b bq=%h bv=%b coll=%b, required all zero",
                       k, aq[k], av[k], bq[k], bv[k], cl[k]);
            end
        end
        rstn = 1'b1;

        // Basic write then read
        cycle(1, 4'hF, 12'h010, 32'hDEADBEEF, 0, 4'h0, 12'h0, 32'h0);
        cycle(1, 4'h0, 12'h010, 32'h0,        0, 4'h0, 12'h0, 32'h0);
        idle(5);

        // Lane masking
        cycle(1, 4'hF,    12'h020, 32'h11223344, 0, 4'h0, 12'h0, 32'h0);
        cycle(1, 4'b0101, 12'h020, 32'hAABBCCDD, 0, 4'h0, 12'h0, 32'h0);
        cycle(1, 4'h0,    12'h020, 32'h0,        0, 4'h0, 12'h0, 32'h0);
        idle(5);

        // Same-port read during write on both ports
        cycle(1, 4'hF, 12'h030, 32'h1, 1, 4'hF, 12'h031, 32'h5);
        cycle(1, 4'h0, 12'h030, 32'h0, 1, 4'h0, 12'h031, 32'h0);
        cycle(1, 4'hF, 12'h030, 32'h2, 1, 4'hF, 12'h031, 32'h6);
        cycle(1, 4'h0, 12'h030, 32'h0, 1, 4'h0, 12'h031, 32'h0);
        idle(5);

        // Collision, then disjoint lanes, then overlapping lanes at different addresses
        cycle(1, 4'hF,    12'h040, 32'h0,        1, 4'hF,    12'h041, 32'h0);
        cycle(1, 4'b0011, 12'h040, 32'hAAAAAAAA, 1, 4'b0110, 12'h040, 32'hBBBBBBBB);
        cycle(1, 4'h0,    12'h040, 32'h0,        1, 4'h0,    12'h040, 32'h0);
        cycle(1, 4'b0001, 12'h041, 32'h12345678, 1, 4'b0010, 12'h041, 32'h9ABCDEF0);
        cycle(1, 4'hF,    12'h042, 32'h1,        1, 4'hF,    12'h043, 32'h2);
        cycle(1, 4'h0,    12'h041, 32'h0,        1, 4'h0,    12'h042, 32'h0);
        idle(5);

        // Back-to-back streams of ascending/descending addresses
        for (int i = 0; i < 8; i += 2)
            cycle(1, 4'hF, 12'(12'h100 + i), 32'(32'hC0DE0000 + i),
                  1, 4'hF, 12'(12'h101 + i), 32'(32'hC0DE0001 + i));
        for (int i = 0; i < 8; i++)
            cycle(1, 4'h0, 12'(12'h100 + i), 32'h0, 1, 4'h0, 12'(12'h107 - i), 32'h0);
        idle(6);

        // Mixed traffic confined to initialised words
        for (int i = 0; i < 40; i++)
            cycle(1'($urandom_range(0, 1)), 4'($urandom), 12'(12'h100 + $urandom_range(0, 7)), $urandom,
                  1'($urandom_range(0, 1)), 4'($urandom), 12'(12'h100 + $urandom_range(0, 7)), $urandom);
        idle(6);

        // Reset with reads in flight
        cycle(1, 4'h0, 12'h010, 32'h0, 1, 4'h0, 12'h100, 32'h0);
        idle(1);
        #2;
        reset_start();
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        idle(3);
        cycle(1, 4'h0, 12'h010, 32'h0, 1, 4'h0, 12'h100, 32'h0);
        cycle(1, 4'h0, 12'h020, 32'h0, 1, 4'h0, 12'h040, 32'h0);
        idle(8);

        for (int k = 0; k < NCFG; k++) begin
            checks++;
            assert (sbq[k][0].size() == 0 && sbq[k][1].size() == 0) else begin
                errors++;
                $error("FAIL drain cfg%0d: pending a=%0d b=%0d, required 0 0",
                       k, sbq[k][0].size(), sbq[k][1].size());
            end
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
